// File: rtl/f2_stage.sv
// F2 fetch stage: tracks the one outstanding instruction-memory request
// for the F1 entry, buffers the response under D1 back-pressure, and drains responses orphaned by a flush.
module f2_stage (
  input  logic        clock,
  input  logic        reset,
  input  logic        F1_Valid,
  input  logic [31:0] F1_FetchPC,
  input  logic        F1_IsBDS,
  input  logic        F1_Exception,
  input  logic [4:0]  F1_ExcCode,
  input  logic        F1_XOP_Restart,
  output logic        F1_Stall,
  input  logic        InstMem_Ready,
  input  logic [31:0] InstMem_Data,
  input  logic        InstMem_Error,
  input  logic        D1_Stall,
  input  logic        F2_Flush,
  output logic        F2_Issued,
  output logic [31:0] F2_Instruction,
  output logic [31:0] F2_FetchPC,
  output logic [31:0] F2_PCAdd4,
  output logic        F2_IsBDS,
  output logic        F2_Exception,
  output logic [4:0]  F2_ExcCode,
  output logic        F2_XOP_Restart
);

  typedef enum logic [1:0] {S_EMPTY, S_WAIT, S_HOLD, S_DRAIN} state_t;

  localparam logic [4:0] EXC_IBE = 5'h06;

  state_t      state, state_nxt, state_fill;
  logic [31:0] pc_q, instr_q;
  logic        bds_q, xop_q, exc_q;
  logic [4:0]  code_q;
  logic        accept, rsp, rsp_err, load_rsp;

  assign rsp      = (state == S_WAIT) & InstMem_Ready;
  assign rsp_err  = rsp & InstMem_Error;
  assign F1_Stall = ((state == S_WAIT) & ~(InstMem_Ready & ~D1_Stall)) |
                    ((state == S_HOLD) & D1_Stall) |
                    (state == S_DRAIN);
  assign accept   = F1_Valid & ~F1_Stall & ~F2_Flush;
  // a response D1 cannot take yet is parked in the hold register
  assign load_rsp = rsp & D1_Stall & ~F2_Flush;

  assign F2_Issued      = ~F2_Flush & (rsp | (state == S_HOLD));
  assign F2_Instruction = (state == S_WAIT) ? (rsp_err ? 32'h0 : InstMem_Data) : instr_q;
  assign F2_Exception   = (state == S_HOLD) ? exc_q : rsp_err;
  assign F2_ExcCode     = rsp_err ? EXC_IBE : code_q;
  assign F2_FetchPC     = pc_q;
  assign F2_PCAdd4      = pc_q + 32'd4;
  assign F2_IsBDS       = bds_q;
  assign F2_XOP_Restart = xop_q;

  always_comb begin
    state_fill = S_EMPTY;
    if (accept) state_fill = F1_Exception ? S_HOLD : S_WAIT;
    state_nxt = state;
    if (F2_Flush) begin
      // a request still in flight must have its response swallowed
      if ((state == S_WAIT || state == S_DRAIN) && !InstMem_Ready) state_nxt = S_DRAIN;
      else                                                         state_nxt = S_EMPTY;
    end else begin
      case (state)
        S_EMPTY: state_nxt = state_fill;
        S_WAIT:  if (InstMem_Ready) state_nxt = D1_Stall ? S_HOLD : state_fill;
        S_HOLD:  if (!D1_Stall)     state_nxt = state_fill;
        S_DRAIN: if (InstMem_Ready) state_nxt = S_EMPTY;
        default: state_nxt = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_EMPTY;
    else        state <= state_nxt;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_q    <= 32'h0;
      instr_q <= 32'h0;
      bds_q   <= 1'b0;
      xop_q   <= 1'b0;
      exc_q   <= 1'b0;
      code_q  <= 5'h0;
    end else if (accept) begin
      pc_q    <= F1_FetchPC;
      instr_q <= 32'h0;
      bds_q   <= F1_IsBDS;
      xop_q   <= F1_XOP_Restart;
      exc_q   <= F1_Exception;
      code_q  <= F1_ExcCode;
    end else if (load_rsp) begin
      instr_q <= InstMem_Error ? 32'h0 : InstMem_Data;
      exc_q   <= exc_q | InstMem_Error;
      if (InstMem_Error) code_q <= EXC_IBE;
    end
  end

endmodule

// File: tb/tb_f2_stage.sv
// Bench for f2_stage: directed vector table, async-reset sequence, then
// randomized traffic checked against an entry-level behavioural model.
module tb_f2_stage;

  logic        clock = 1'b0, reset = 1'b0;
  logic        F1_Valid = 1'b0, F1_IsBDS = 1'b0, F1_Exception = 1'b0, F1_XOP_Restart = 1'b0;
  logic [31:0] F1_FetchPC = 32'h0, InstMem_Data = 32'h0;
  logic [4:0]  F1_ExcCode = 5'h0;
  logic        InstMem_Ready = 1'b0, InstMem_Error = 1'b0, D1_Stall = 1'b0, F2_Flush = 1'b0;
  logic        F1_Stall, F2_Issued, F2_IsBDS, F2_Exception, F2_XOP_Restart;
  logic [31:0] F2_Instruction, F2_FetchPC, F2_PCAdd4;
  logic [4:0]  F2_ExcCode;

  int checks = 0, failures = 0;

  always #5 clock = ~clock;

  f2_stage dut (
    .clock(clock), .reset(reset),
    .F1_Valid(F1_Valid), .F1_FetchPC(F1_FetchPC), .F1_IsBDS(F1_IsBDS),
    .F1_Exception(F1_Exception), .F1_ExcCode(F1_ExcCode), .F1_XOP_Restart(F1_XOP_Restart),
    .F1_Stall(F1_Stall),
    .InstMem_Ready(InstMem_Ready), .InstMem_Data(InstMem_Data), .InstMem_Error(InstMem_Error),
    .D1_Stall(D1_Stall), .F2_Flush(F2_Flush),
    .F2_Issued(F2_Issued), .F2_Instruction(F2_Instruction), .F2_FetchPC(F2_FetchPC),
    .F2_PCAdd4(F2_PCAdd4), .F2_IsBDS(F2_IsBDS), .F2_Exception(F2_Exception),
    .F2_ExcCode(F2_ExcCode), .F2_XOP_Restart(F2_XOP_Restart)
  );

  typedef struct {
    logic vld; logic [31:0] pc; logic exc; logic [4:0] code;
    logic rdy; logic [31:0] data; logic err; logic d1; logic flush;
    logic e_stall; logic e_iss; logic chk;
    logic [31:0] e_instr; logic [31:0] e_add4; logic e_exc; logic [4:0] e_code;
  } vec_t;

  vec_t tbl[$];

  task automatic vec(input logic vld, input logic [31:0] pc, input logic exc, input logic [4:0] code,
                     input logic rdy, input logic [31:0] data, input logic err, input logic d1,
                     input logic flush, input logic e_stall, input logic e_iss, input logic chk,
                     input logic [31:0] e_instr, input logic [31:0] e_add4, input logic e_exc,
                     input logic [4:0] e_code);
    vec_t v;
    v = '{vld, pc, exc, code, rdy, data, err, d1, flush, e_stall, e_iss, chk, e_instr, e_add4, e_exc, e_code};
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic vld, input logic [31:0] pc, input logic exc, input logic [4:0] code,
                       input logic rdy, input logic [31:0] data, input logic err, input logic d1,
                       input logic flush);
    F1_Valid = vld; F1_FetchPC = pc; F1_Exception = exc; F1_ExcCode = code;
    InstMem_Ready = rdy; InstMem_Data = data; InstMem_Error = err;
    D1_Stall = d1; F2_Flush = flush;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_issued"}, 32'(F2_Issued), 32'h0);
    chk({tag, "_stall"},  32'(F1_Stall), 32'h0);
    chk({tag, "_exc"},    32'(F2_Exception), 32'h0);
    chk({tag, "_pc"},     F2_FetchPC, 32'h0);
    chk({tag, "_add4"},   F2_PCAdd4, 32'h4);
    chk({tag, "_instr"},  F2_Instruction, 32'h0);
  endtask

  // Behavioural model: one optional entry, plus whether its memory word is
  // still awaited, already in hand, or a flushed request's reply is pending.
  logic        m_wait, m_held, m_drain, m_bds, m_xop, m_exc;
  logic [31:0] m_pc, m_instr;
  logic [4:0]  m_code;

  task automatic model_clear();
    m_wait = 1'b0; m_held = 1'b0; m_drain = 1'b0;
    m_pc = 32'h0; m_instr = 32'h0; m_bds = 1'b0; m_xop = 1'b0; m_exc = 1'b0; m_code = 5'h0;
  endtask

  function automatic logic model_stall();
    return (m_wait && !(InstMem_Ready && !D1_Stall)) || (m_held && D1_Stall) || m_drain;
  endfunction

  task automatic model_check(input int cyc);
    logic        e_iss;
    logic [31:0] e_instr;
    logic        e_exc;
    logic [4:0]  e_code;
    e_iss = !F2_Flush && ((m_wait && InstMem_Ready) || m_held);
    if (m_wait) begin
      e_instr = InstMem_Error ? 32'h0 : InstMem_Data;
      e_exc   = InstMem_Error;
      e_code  = 5'h06;
    end else begin
      e_instr = m_instr; e_exc = m_exc; e_code = m_code;
    end
    chk($sformatf("rnd%0d_stall", cyc), 32'(F1_Stall), 32'(model_stall()));
    chk($sformatf("rnd%0d_issued", cyc), 32'(F2_Issued), 32'(e_iss));
    if (e_iss) begin
      chk($sformatf("rnd%0d_instr", cyc), F2_Instruction, e_instr);
      chk($sformatf("rnd%0d_pc", cyc), F2_FetchPC, m_pc);
      chk($sformatf("rnd%0d_add4", cyc), F2_PCAdd4, m_pc + 32'd4);
      chk($sformatf("rnd%0d_bds_xop", cyc), {30'h0, F2_IsBDS, F2_XOP_Restart}, {30'h0, m_bds, m_xop});
      chk($sformatf("rnd%0d_exc", cyc), 32'(F2_Exception), 32'(e_exc));
      if (e_exc) chk($sformatf("rnd%0d_code", cyc), 32'(F2_ExcCode), 32'(e_code));
    end
  endtask

  task automatic model_step();
    logic acc, consumed, empty;
    acc = F1_Valid && !model_stall() && !F2_Flush;
    if (F2_Flush) begin
      m_drain = (m_wait || m_drain) && !InstMem_Ready;
      m_wait = 1'b0; m_held = 1'b0;
    end else if (m_drain) begin
      if (InstMem_Ready) m_drain = 1'b0;
    end else begin
      empty    = !m_wait && !m_held;
      consumed = (m_wait && InstMem_Ready && !D1_Stall) || (m_held && !D1_Stall);
      if (m_wait && InstMem_Ready && D1_Stall) begin
        m_wait = 1'b0; m_held = 1'b1;
        m_instr = InstMem_Error ? 32'h0 : InstMem_Data;
        m_exc = InstMem_Error;
        if (InstMem_Error) m_code = 5'h06;
      end
      if (consumed) begin m_wait = 1'b0; m_held = 1'b0; end
      if ((consumed || empty) && acc) begin
        m_pc = F1_FetchPC; m_bds = F1_IsBDS; m_xop = F1_XOP_Restart;
        m_exc = F1_Exception; m_code = F1_ExcCode; m_instr = 32'h0;
        m_wait = !F1_Exception; m_held = F1_Exception;
      end
    end
  endtask

  initial begin
    //   vld  pc            exc   code   rdy   data          err   d1    fl    stall iss   chk   instr         add4          exc   code
    vec(1'b1, 32'h00400000, 1'b0, 5'h0,  1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 5'h0);
    vec(1'b0, 32'h0,        1'b0, 5'h0,  1'b1, 32'h24020001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h24020001, 32'h00400004, 1'b0, 5'h0);
    vec(1'b1, 32'h00400010, 1'b0, 5'h0,  1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 5'h0);
    vec(1'b1, 32'h00400014, 1'b0, 5'h0,  1'b1, 32'hAABBCCDD, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'hAABBCCDD, 32'h00400014, 1'b0, 5'h0);
    vec(1'b1, 32'h00400014, 1'b0, 5'h0,  1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'hAABBCCDD, 32'h00400014, 1'b0, 5'h0);
    vec(1'b1, 32'h00400014, 1'b0, 5'h0,  1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'hAABBCCDD, 32'h00400014, 1'b0, 5'h0);
    vec(1'b1, 32'h00400014, 1'b0, 5'h0,  1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'hAABBCCDD, 32'h00400014, 1'b0, 5'h0);
    vec(1'b1, 32'h00400018, 1'b1, 5'h04, 1'b1, 32'h11111111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h11111111, 32'h00400018, 1'b0, 5'h0);
    vec(1'b0, 32'h0,        1'b0, 5'h0,  1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0,        32'h0040001C, 1'b1, 5'h04);
    vec(1'b0, 32'h0,        1'b0, 5'h0,  1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0,        32'h0040001C, 1'b1, 5'h04);
    vec(1'b1, 32'hFFFFFFFC, 1'b0, 5'h0,  1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 5'h0);
    vec(1'b0, 32'h0,        1'b0, 5'h0,  1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0,        32'h0,        1'b1, 5'h06);
    vec(1'b1, 32'h00500000, 1'b0, 5'h0,  1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 5'h0);
    vec(1'b1, 32'h00500004, 1'b0, 5'h0,  1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 5'h0);
    vec(1'b1, 32'h00500004, 1'b0, 5'h0,  1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 5'h0);
    vec(1'b1, 32'h00500004, 1'b0, 5'h0,  1'b1, 32'h12345678, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 5'h0);
    vec(1'b0, 32'h0,        1'b0, 5'h0,  1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 5'h0);
    vec(1'b0, 32'h0,        1'b0, 5'h0,  1'b1, 32'h00000055, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 5'h0);

    // reset state
    repeat (2) @(posedge clock);
    #1 chk_reset_vals("reset");
    @(negedge clock) reset = 1'b1;
    @(posedge clock); #1;

    foreach (tbl[i]) begin
      drive(tbl[i].vld, tbl[i].pc, tbl[i].exc, tbl[i].code, tbl[i].rdy, tbl[i].data,
            tbl[i].err, tbl[i].d1, tbl[i].flush);
      @(negedge clock);
      chk($sformatf("vec%0d_stall", i), 32'(F1_Stall), 32'(tbl[i].e_stall));
      chk($sformatf("vec%0d_issued", i), 32'(F2_Issued), 32'(tbl[i].e_iss));
      if (tbl[i].chk) begin
        chk($sformatf("vec%0d_instr", i), F2_Instruction, tbl[i].e_instr);
        chk($sformatf("vec%0d_add4", i), F2_PCAdd4, tbl[i].e_add4);
        chk($sformatf("vec%0d_exc", i), 32'(F2_Exception), 32'(tbl[i].e_exc));
        if (tbl[i].e_exc) chk($sformatf("vec%0d_code", i), 32'(F2_ExcCode), 32'(tbl[i].e_code));
      end
      @(posedge clock); #1;
    end

    // async reset in the middle of WAIT, then a late response after release
    drive(1'b1, 32'h00600000, 1'b0, 5'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clock) chk("arst_accept_stall", 32'(F1_Stall), 32'h0);
    @(posedge clock); #1;
    drive(1'b0, 32'h0, 1'b0, 5'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    #1 chk("arst_wait_stall", 32'(F1_Stall), 32'h1);
    #1 reset = 1'b0;
    #1 InstMem_Ready = 1'b1; InstMem_Data = 32'h00000077;
    #0 chk_reset_vals("arst");
    @(posedge clock);
    @(negedge clock) reset = 1'b1;
    drive(1'b1, 32'h00700000, 1'b0, 5'h0, 1'b1, 32'h00000077, 1'b0, 1'b0, 1'b0);
    #1 chk("late_rdy_issued", 32'(F2_Issued), 32'h0);
    chk("late_rdy_stall", 32'(F1_Stall), 32'h0);
    @(posedge clock); #1;
    drive(1'b0, 32'h0, 1'b0, 5'h0, 1'b1, 32'h3C000001, 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    chk("post_rst_issued", 32'(F2_Issued), 32'h1);
    chk("post_rst_instr", F2_Instruction, 32'h3C000001);
    chk("post_rst_pc", F2_FetchPC, 32'h00700000);
    chk("post_rst_add4", F2_PCAdd4, 32'h00700004);
    @(posedge clock); #1;

    // randomized traffic against the model
    drive(1'b0, 32'h0, 1'b0, 5'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    model_clear();
    @(negedge clock) reset = 1'b1;
    @(posedge clock); #1;
    for (int c = 0; c < 3000; c++) begin
      F1_Valid       = ($urandom_range(0, 9) < 7);
      F1_FetchPC     = {$urandom(), 2'b00} ^ (($urandom_range(0, 15) == 0) ? 32'hFFFFFFFC : 32'h0);
      F1_IsBDS       = 1'($urandom_range(0, 1));
      F1_XOP_Restart = 1'($urandom_range(0, 1));
      F1_Exception   = ($urandom_range(0, 99) < 15);
      F1_ExcCode     = 5'($urandom_range(0, 31));
      InstMem_Ready  = 1'($urandom_range(0, 1));
      InstMem_Data   = $urandom();
      InstMem_Error  = ($urandom_range(0, 99) < 15);
      D1_Stall       = ($urandom_range(0, 99) < 30);
      F2_Flush       = ($urandom_range(0, 99) < 8);
      @(negedge clock);
      model_check(c);
      @(posedge clock);
      model_step();
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
